// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor (D = in_a - in_b), LSB first,
// one bit per clock, with start/busy/done handshake and ALU-style status flags.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_q, b_q, r_q, r_nxt;
    logic [CW-1:0]    cnt_q;
    logic             bw_q, sa_q, sb_q;
    logic             load, last, a0, b0, d_bit, bw_nxt;

    // Start is only honoured outside SHIFT, so a busy operation is never disturbed.
    assign load = start && (state != SHIFT);
    assign last = (state == SHIFT) && (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        a0     = a_q[0];
        b0     = b_q[0];
        d_bit  = a0 ^ b0 ^ bw_q;
        bw_nxt = (~a0 & b0) | (~(a0 ^ b0) & bw_q);
        r_nxt  = {d_bit, r_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = load ? SHIFT : last ? FIN : (state == SHIFT) ? SHIFT : IDLE;
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            cnt_q <= '0;
            bw_q  <= 1'b0;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
        end else if (load) begin
            a_q   <= in_a;
            b_q   <= in_b;
            r_q   <= '0;
            cnt_q <= '0;
            bw_q  <= 1'b0;
            sa_q  <= in_a[WIDTH-1];
            sb_q  <= in_b[WIDTH-1];
        end else if (state == SHIFT) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            r_q   <= r_nxt;
            cnt_q <= cnt_q + CW'(1);
            bw_q  <= bw_nxt;
        end
    end

    // Results are taken from the in-flight values on the final bit so they appear with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d      <= '0;
            borrow <= 1'b0;
            zero   <= 1'b1;
            neg    <= 1'b0;
            ovf    <= 1'b0;
        end else if (last) begin
            d      <= r_nxt;
            borrow <= bw_nxt;
            zero   <= (r_nxt == '0);
            neg    <= d_bit;
            ovf    <= (sa_q != sb_q) && (d_bit != sa_q);
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       busy, done, borrow, zero, neg, ovf;
    logic [7:0] d;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_a(in_a), .in_b(in_b),
        .busy(busy), .done(done), .d(d), .borrow(borrow), .zero(zero), .neg(neg), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, d, borrow, zero, neg, ovf} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b d=%h b=%b z=%b n=%b o=%b, want 0 0 00 0 1 0 0",
                     busy, done, d, borrow, zero, neg, ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sub(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                            input logic eb, input logic ez, input logic en, input logic eo);
        int n;
        in_a = a; in_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_a = 8'($urandom); in_b = 8'($urandom);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL sub_busy %h-%h: got busy=%b want 1", a, b, busy);
        end
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 9) begin
            errors++;
            $display("FAIL sub_latency %h-%h: got %0d cycles want 9", a, b, n);
        end
        checks++;
        if ({d, borrow, zero, neg, ovf, busy} !== {ed, eb, ez, en, eo, 1'b0}) begin
            errors++;
            $display("FAIL sub_result %h-%h: got d=%h b=%b z=%b n=%b o=%b busy=%b want d=%h b=%b z=%b n=%b o=%b busy=0",
                     a, b, d, borrow, zero, neg, ovf, busy, ed, eb, ez, en, eo);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || d !== ed) begin
            errors++;
            $display("FAIL sub_hold %h-%h: got done=%b d=%h want done=0 d=%h", a, b, done, d, ed);
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        int first = 0;
        logic busy_ok = 1'b1;
        in_a = 8'h5A; in_b = 8'h5A; start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            start = (i == 3);
            if (i == 3) begin in_a = 8'hFF; in_b = 8'h00; end
            if (i >= 1 && i <= 8 && busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                dones++;
                if (first == 0) first = i;
            end
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL ignore_busy: got busy dropped during operation want busy high cycles 1..8");
        end
        checks++;
        if (dones !== 1 || first !== 9) begin
            errors++;
            $display("FAIL ignore_done: got %0d pulses first at %0d want 1 pulse at 9", dones, first);
        end
        checks++;
        if (d !== 8'h00 || zero !== 1'b1 || borrow !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result: got d=%h z=%b b=%b want d=00 z=1 b=0", d, zero, borrow);
        end
    endtask

    task automatic test_back_to_back();
        int c1 = 0;
        int c2 = 0;
        int bad_busy = 0;
        logic [7:0] d1 = '0;
        logic [7:0] d2 = '0;
        in_a = 8'd9; in_b = 8'd4; start = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (i == 1) begin in_a = 8'd4; in_b = 8'd9; end
            if (busy !== !(i == 9 || i == 18)) bad_busy++;
            if (done === 1'b1) begin
                if (c1 == 0) begin c1 = i; d1 = d; end
                else if (c2 == 0) begin c2 = i; d2 = d; end
            end
        end
        start = 1'b0;
        checks++;
        if (c1 !== 9 || c2 !== 18) begin
            errors++;
            $display("FAIL b2b_timing: got done at %0d,%0d want 9,18", c1, c2);
        end
        checks++;
        if (d1 !== 8'h05 || d2 !== 8'hFB) begin
            errors++;
            $display("FAIL b2b_results: got %h,%h want 05,fb", d1, d2);
        end
        checks++;
        if (bad_busy !== 0) begin
            errors++;
            $display("FAIL b2b_busy: got %0d wrong busy cycles want 0", bad_busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_async_reset();
        int dones = 0;
        in_a = 8'd200; in_b = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, d, borrow, zero, neg, ovf} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b d=%h b=%b z=%b n=%b o=%b, want 0 0 00 0 1 0 0",
                     busy, done, d, borrow, zero, neg, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL reset_abort: got %0d active cycles after reset want 0", dones);
        end
        test_sub(8'd3, 8'd1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_sub(8'd100, 8'd37, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0);
        test_sub(8'd37, 8'd100, 8'hC1, 1'b1, 1'b0, 1'b1, 1'b0);
        test_sub(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
        test_sub(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1);
        test_sub(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        test_ignore_start();
        @(negedge clk);
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
